mult_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one multi-cycle multiplier among NREQ requesters.
- Each requester presents a signed operand pair with a level request.
- The block grants one requester, drives the multiplier operands and holds them for the multiplier latency, then captures the product and returns it with a one-cycle done pulse.
- Sits between the dot-product style datapath engines and the single shared mult instance.

---
 rtl/mult_share_arb_if.sv | 30 +++
 rtl/mult_share_arb.sv | 120 ++++++++++++
 tb/tb_mult_share_arb.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arb_if.sv
// Requester and multiplier-side signals of the shared-multiplier arbiter.
// slave is the arbiter's view; master is the requesters plus the multiplier.
interface mult_share_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic [IDW-1:0]        result_id;
    logic                  busy;
    logic [WIDTH-1:0]      mult_a;
    logic [WIDTH-1:0]      mult_b;
    logic [WIDTH-1:0]      mult_p;

    modport slave (
        input  req, a_in, b_in, mult_p,
        output gnt, done, result, result_id, busy, mult_a, mult_b
    );

    modport master (
        output req, a_in, b_in, mult_p,
        input  gnt, done, result, result_id, busy, mult_a, mult_b
    );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin sequencer sharing one multi-cycle multiplier: grants a requester,
// holds its operands for MULT_LAT cycles, captures the product and pulses done.
module mult_share_arb #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 16,
    parameter int MULT_LAT = 79
) (
    input  logic            clk,
    input  logic            reset,
    mult_share_arb_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_next;
    logic [7:0]       cnt;
    logic             cnt_last;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   scan_idx;
    logic [IDW:0]     scan_sum;
    logic             found;
    logic [NREQ-1:0]  win_onehot;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  done_c;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = bus.a_in[g*WIDTH +: WIDTH];
        assign b_arr[g] = bus.b_in[g*WIDTH +: WIDTH];
    end

    assign cnt_last = (cnt == 8'(MULT_LAT - 1));

    // Scan upward from the pointer, wrapping, and take the first active request.
    always_comb begin
        winner     = ptr;
        found      = 1'b0;
        scan_sum   = '0;
        scan_idx   = '0;
        win_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!found && bus.req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
        win_onehot[winner] = 1'b1;
    end

    always_comb begin
        state_next = state;
        done_c     = '0;
        case (state)
            IDLE:    if (found) state_next = WAIT;
            WAIT:    if (cnt_last) state_next = DONE;
            DONE: begin
                state_next   = IDLE;
                done_c[id_q] = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            gnt_q    <= '0;
            id_q     <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        a_q   <= a_arr[winner];
                        b_q   <= b_arr[winner];
                        gnt_q <= win_onehot;
                        id_q  <= winner;
                        cnt   <= '0;
                        ptr   <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (cnt_last) begin
                        result_q <= bus.mult_p;
                    end
                end
                DONE:    gnt_q <= '0;
                default: gnt_q <= '0;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_c;
    assign bus.result    = result_q;
    assign bus.result_id = id_q;
    assign bus.busy      = (state != IDLE);
    assign bus.mult_a    = a_q;
    assign bus.mult_b    = b_q;
endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: short-latency instance driven from a vector table and
// scoreboard, plus a default-latency instance for the long-latency case.
module tb_mult_share_arb;
    localparam int NREQ     = 4;
    localparam int WIDTH    = 16;
    localparam int LAT      = 4;
    localparam int LAT_LONG = 79;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
    mult_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) busl ();

    mult_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MULT_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    mult_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dutl (
        .clk(clk), .reset(reset), .bus(busl)
    );

    // Multiplier models: product emerges LAT-1 edges after the operands, so it is
    // valid only once the operands have been held for the full latency.
    logic [WIDTH-1:0] pipe  [0:LAT-2];
    logic [WIDTH-1:0] pipel [0:LAT_LONG-2];
    always @(posedge clk) begin
        pipe[0]  <= WIDTH'(bus.mult_a * bus.mult_b);
        pipel[0] <= WIDTH'(busl.mult_a * busl.mult_b);
        for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
        for (int k = 1; k < LAT_LONG - 1; k++) pipel[k] <= pipel[k-1];
    end
    assign bus.mult_p  = pipe[LAT-2];
    assign busl.mult_p = pipel[LAT_LONG-2];

    typedef struct {
        int               slot;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
    } vec_t;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req_val);
        total++;
        if (act !== req_val) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, req_val);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int s);
        onehot = 4'b0001 << s;
    endfunction

    function automatic logic [NREQ*WIDTH-1:0] place(input int s, input logic [WIDTH-1:0] v);
        logic [NREQ*WIDTH-1:0] r;
        r = '0;
        r[s*WIDTH +: WIDTH] = v;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] a,
                                 input logic [NREQ*WIDTH-1:0] b);
        bus.req  = r;
        bus.a_in = a;
        bus.b_in = b;
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done !== '0) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("done_onehot", 32'(bus.done), 32'(onehot(e.id)));
                checkOutput("result", 32'(bus.result), 32'(e.res));
                checkOutput("result_id", 32'(bus.result_id), e.id);
                checkOutput("gnt_at_done", 32'(bus.gnt), 32'(onehot(e.id)));
            end
        end
    end

    // Called on the cycle the grant should be visible; returns on the cycle after the bubble.
    task automatic serveOne(input int slot, input logic [WIDTH-1:0] ea,
                            input logic [WIDTH-1:0] eb, input bit last);
        checkOutput("gnt", 32'(bus.gnt), 32'(onehot(slot)));
        checkOutput("mult_a", 32'(bus.mult_a), 32'(ea));
        checkOutput("mult_b", 32'(bus.mult_b), 32'(eb));
        checkOutput("busy", 32'(bus.busy), 32'd1);
        tick(LAT - 1);
        checkOutput("done_early", 32'(bus.done), 32'd0);
        tick(1);
        checkOutput("done_time", 32'(bus.done), 32'(onehot(slot)));
        checkOutput("mult_a_held", 32'(bus.mult_a), 32'(ea));
        checkOutput("mult_b_held", 32'(bus.mult_b), 32'(eb));
        if (last) bus.req = '0;
        tick(1);
        checkOutput("bubble_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("bubble_busy", 32'(bus.busy), 32'd0);
        tick(1);
    endtask

    vec_t vecs [5];
    logic [NREQ-1:0] seen_done;
    int n;

    initial begin
        vecs[0] = '{0, 16'd3,    16'hFFFB, 16'hFFF1};
        vecs[1] = '{1, 16'hFFF9, 16'hFFFA, 16'h002A};
        vecs[2] = '{2, 16'h0100, 16'h0100, 16'h0000};
        vecs[3] = '{0, 16'hFFFF, 16'h0001, 16'hFFFF};
        vecs[4] = '{3, 16'h7FFF, 16'h7FFF, 16'h0001};

        reset = 1'b1;
        applyStimulus('0, '0, '0);
        busl.req  = '0;
        busl.a_in = '0;
        busl.b_in = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_result", 32'(bus.result), 32'd0);
        checkOutput("rst_result_id", 32'(bus.result_id), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_mult_a", 32'(bus.mult_a), 32'd0);
        checkOutput("rst_mult_b", 32'(bus.mult_b), 32'd0);
        checkOutput("rst_long_busy", 32'(busl.busy), 32'd0);

        // Single-requester transactions; the last one leaves the pointer at 0.
        foreach (vecs[i]) begin
            applyStimulus(onehot(vecs[i].slot), place(vecs[i].slot, vecs[i].a),
                          place(vecs[i].slot, vecs[i].b));
            sbq.push_back('{vecs[i].slot, vecs[i].res});
            tick(1);
            serveOne(vecs[i].slot, vecs[i].a, vecs[i].b, 1'b1);
        end

        // All requesting continuously: rotation 0,1,2,3,0.
        applyStimulus(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}});
        for (int i = 0; i < 5; i++) sbq.push_back('{i % 4, 16'(2 * ((i % 4) + 1))});
        tick(1);
        for (int i = 0; i < 5; i++) serveOne(i % 4, 16'((i % 4) + 1), 16'd2, i == 4);

        // Serve 1 alone so the pointer is 2, then 0 and 1 together: 0 first, then 1.
        applyStimulus(4'b0010, place(1, 16'd5), place(1, 16'd6));
        sbq.push_back('{1, 16'd30});
        tick(1);
        serveOne(1, 16'd5, 16'd6, 1'b1);
        applyStimulus(4'b0011, {16'd0, 16'd0, 16'd7, 16'd8}, {4{16'd1}});
        sbq.push_back('{0, 16'd8});
        sbq.push_back('{1, 16'd7});
        tick(1);
        serveOne(0, 16'd8, 16'd1, 1'b0);
        serveOne(1, 16'd7, 16'd1, 1'b1);

        // Inputs change and req drops during WAIT: the original product still returns.
        applyStimulus(4'b0100, place(2, 16'd5), place(2, 16'd9));
        sbq.push_back('{2, 16'd45});
        tick(1);
        checkOutput("frz_gnt", 32'(bus.gnt), 32'(onehot(2)));
        tick(1);
        applyStimulus(4'b0000, {4{16'd11}}, {4{16'd13}});
        tick(LAT - 2);
        checkOutput("frz_mult_a", 32'(bus.mult_a), 32'd5);
        checkOutput("frz_mult_b", 32'(bus.mult_b), 32'd9);
        tick(1);
        checkOutput("frz_done", 32'(bus.done), 32'(onehot(2)));
        tick(1);
        checkOutput("frz_gnt_drop", 32'(bus.gnt), 32'd0);

        // Reset mid-WAIT with the pointer at 3: abort silently, then requester 0 wins.
        applyStimulus(4'b0100, place(2, 16'd2), place(2, 16'd2));
        tick(1);
        checkOutput("abort_gnt", 32'(bus.gnt), 32'(onehot(2)));
        tick(2);
        reset = 1'b1;
        tick(1);
        checkOutput("abort_gnt_clr", 32'(bus.gnt), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_mult_a", 32'(bus.mult_a), 32'd0);
        checkOutput("abort_mult_b", 32'(bus.mult_b), 32'd0);
        checkOutput("abort_result_id", 32'(bus.result_id), 32'd0);
        reset = 1'b0;
        applyStimulus('0, '0, '0);
        seen_done = '0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick(1);
            seen_done = seen_done | bus.done;
        end
        checkOutput("abort_no_done", 32'(seen_done), 32'd0);
        applyStimulus(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd3}});
        sbq.push_back('{0, 16'd3});
        tick(1);
        serveOne(0, 16'd1, 16'd3, 1'b1);

        // Default latency instance: done MULT_LAT cycles after grant, truncated product.
        busl.req  = 4'b0001;
        busl.a_in = place(0, 16'h7FFF);
        busl.b_in = place(0, 16'd2);
        tick(1);
        n = 0;
        while (busl.gnt == '0 && n < 5) begin
            tick(1);
            n++;
        end
        checkOutput("long_gnt", 32'(busl.gnt), 32'd1);
        n = 0;
        while (busl.done == '0 && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("long_latency", n, LAT_LONG);
        checkOutput("long_done", 32'(busl.done), 32'd1);
        checkOutput("long_result", 32'(busl.result), 32'hFFFE);
        checkOutput("long_result_id", 32'(busl.result_id), 32'd0);
        busl.req = '0;
        tick(3);

        checkOutput("scoreboard_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
